// File: rtl/auto_range_ctrl.sv
// auto_range_ctrl: measurement sequencer for a frequency counter.
// Runs a CLEAR / GATE / SETTLE / EVAL / STORE cycle, times the gate window
// from a 1 ms prescaler, and optionally steps the range up or down.
// Optional feature macro: AUTORANGE_EN. When it is defined, the block
// steps the range automatically. When it is undefined, Auto is ignored and
// the range always comes from Man_sel.
module auto_range_ctrl #(
    parameter int TICKS_1MS = 50000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Run,
    input  logic        Auto,
    input  logic [1:0]  Man_sel,
    input  logic [15:0] CNT,
    input  logic        OVF,
    output logic        GATE,
    output logic        CLR,
    output logic        Store,
    output logic [1:0]  F_sel,
    output logic        Busy,
    output logic        Ovr
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_GATE, S_SETTLE, S_EVAL, S_STORE
    } state_t;

    localparam logic [15:0] PRE_LAST = 16'(TICKS_1MS - 1);

    state_t      state, state_nx;
    logic [15:0] pre_cnt, pre_nx;
    logic [9:0]  ms_cnt, ms_nx;
    logic        settle_cnt, settle_nx;
    logic [1:0]  f_sel_nx;
    logic        ovr_nx;
    logic        over, under;

`ifdef AUTORANGE_EN
    logic        auto_q, auto_nx;
`else
    logic        auto_unused;
    assign auto_unused = Auto;
`endif

    // Last ms index of the gate window for a range code (gate_ms - 1)
    function automatic logic [9:0] last_ms(input logic [1:0] f);
        case (f)
            2'b00:   return 10'd999;
            2'b01:   return 10'd99;
            2'b10:   return 10'd9;
            default: return 10'd0;
        endcase
    endfunction

    assign over  = OVF || (CNT > 16'd9999);
    assign under = !OVF && (CNT < 16'd1000);

    // State, counters, range and flag registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= S_IDLE;
            pre_cnt    <= '0;
            ms_cnt     <= '0;
            settle_cnt <= 1'b0;
            F_sel      <= 2'b00;
            Ovr        <= 1'b0;
`ifdef AUTORANGE_EN
            auto_q     <= 1'b0;
`endif
        end else begin
            state      <= state_nx;
            pre_cnt    <= pre_nx;
            ms_cnt     <= ms_nx;
            settle_cnt <= settle_nx;
            F_sel      <= f_sel_nx;
            Ovr        <= ovr_nx;
`ifdef AUTORANGE_EN
            auto_q     <= auto_nx;
`endif
        end
    end

    // Next-state, counter and range decisions
    always_comb begin
        state_nx  = state;
        pre_nx    = pre_cnt;
        ms_nx     = ms_cnt;
        settle_nx = settle_cnt;
        f_sel_nx  = F_sel;
        ovr_nx    = Ovr;
`ifdef AUTORANGE_EN
        auto_nx   = auto_q;
`endif
        case (state)
            S_IDLE: begin
                if (Run) state_nx = S_CLEAR;
            end
            S_CLEAR: begin
                pre_nx    = '0;
                ms_nx     = '0;
                settle_nx = 1'b0;
`ifdef AUTORANGE_EN
                // Mode is frozen here so mid-cycle changes wait for the next CLEAR
                auto_nx = Auto;
                if (!Auto) f_sel_nx = Man_sel;
`else
                f_sel_nx = Man_sel;
`endif
                state_nx = S_GATE;
            end
            S_GATE: begin
                if (pre_cnt == PRE_LAST) begin
                    pre_nx = '0;
                    if (ms_cnt == last_ms(F_sel)) begin
                        settle_nx = 1'b0;
                        state_nx  = S_SETTLE;
                    end else begin
                        ms_nx = ms_cnt + 10'd1;
                    end
                end else begin
                    pre_nx = pre_cnt + 16'd1;
                end
            end
            S_SETTLE: begin
                // Two dead cycles so the counter datapath can finish
                if (settle_cnt) begin
                    settle_nx = 1'b0;
                    state_nx  = S_EVAL;
                end else begin
                    settle_nx = 1'b1;
                end
            end
            S_EVAL: begin
`ifdef AUTORANGE_EN
                if (auto_q && over && (F_sel != 2'b11)) begin
                    f_sel_nx = F_sel + 2'd1;
                    state_nx = S_CLEAR;
                end else if (auto_q && under && (F_sel != 2'b00)) begin
                    f_sel_nx = F_sel - 2'd1;
                    state_nx = S_CLEAR;
                end else begin
                    ovr_nx   = over;
                    state_nx = S_STORE;
                end
`else
                ovr_nx   = over;
                state_nx = S_STORE;
`endif
            end
            S_STORE: begin
                state_nx = Run ? S_CLEAR : S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Moore outputs registered from the next state
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            GATE  <= 1'b0;
            CLR   <= 1'b0;
            Store <= 1'b0;
            Busy  <= 1'b0;
        end else begin
            GATE  <= (state_nx == S_GATE);
            CLR   <= (state_nx == S_CLEAR);
            Store <= (state_nx == S_STORE);
            Busy  <= (state_nx != S_IDLE);
        end
    end

endmodule

// File: doc/auto_range_ctrl.md
AUTO_RANGE_CTRL -- requirements
Module: auto_range_ctrl

Interface
REQ-001 Parameter TICKS_1MS, default 50000: CLK cycles per 1 ms gate unit; legal range 2..65535.
REQ-002 CLK  in  1  system clock; all state updates on rising edge.
REQ-003 RST  in  1  reset, asynchronous and active-high.
REQ-004 Run  in  1  level; 1 = measure continuously, 0 = stop after the current cycle.
REQ-005 Auto  in  1  level; 1 = autorange, 0 = range taken from Man_sel.
REQ-006 Man_sel  in  2  manual range code; sampled only in CLEAR.
REQ-007 CNT  in  16  event count from the counter datapath, valid in EVAL.
REQ-008 OVF  in  1  counter overflow flag, valid in EVAL.
REQ-009 GATE  out  1  counter enable window.
REQ-010 CLR  out  1  one-cycle counter clear pulse.
REQ-011 Store  out  1  one-cycle latch strobe to the display, DotLed and register stages.
REQ-012 F_sel  out  2  current range code.
REQ-013 Busy  out  1  high whenever state is not IDLE.
REQ-014 Ovr  out  1  sticky overrange flag at the shortest gate.

Function
REQ-015 States: IDLE, CLEAR, GATE, SETTLE, EVAL, STORE; outputs are registered (Moore).
REQ-016 IDLE -> CLEAR when Run=1; IDLE holds otherwise.
REQ-017 CLEAR: 1 cycle with CLR=1; load F_sel<=Man_sel if Auto=0; -> GATE.
REQ-018 Gate lengths: F_sel 00 = 1000 ms, 01 = 100 ms, 10 = 10 ms, 11 = 1 ms.
REQ-019 GATE: GATE=1 for exactly gate_ms*TICKS_1MS cycles; -> SETTLE.
REQ-020 Timing uses a 16-bit 1 ms prescaler plus a 10-bit ms counter; both clear on entry to GATE.
REQ-021 SETTLE: exactly 2 cycles with GATE=0, allowing the counter to finish; -> EVAL.
REQ-022 EVAL (1 cycle), overrange: (OVF=1 or CNT>9999) with Auto=1 and F_sel!=11 -> F_sel<=F_sel+1, -> CLEAR, no Store.
REQ-023 EVAL, underrange: CNT<1000 and OVF=0 with Auto=1 and F_sel!=00 -> F_sel<=F_sel-1, -> CLEAR, no Store.
REQ-024 EVAL, otherwise -> STORE; Ovr<=1 if (OVF or CNT>9999) at F_sel=11 or with Auto=0.
REQ-025 Ovr clears on the next STORE that has an in-range count.
REQ-026 STORE: Store=1 for 1 cycle; -> CLEAR if Run=1, else -> IDLE.
REQ-027 F_sel changes only in CLEAR or EVAL, so it is stable for at least 1 cycle before and after the Store rising edge.
REQ-028 Run falling mid-cycle does not abort the cycle; the cycle completes through STORE and then enters IDLE.
REQ-029 Auto or Man_sel changes mid-cycle take effect at the next CLEAR only.
REQ-030 Range step is at most one code per EVAL; F_sel does not wrap.

Reset
REQ-031 RST=1 forces IDLE, GATE=0, CLR=0, Store=0, F_sel=00, Busy=0, Ovr=0, and all counters to 0, immediately and asynchronously.
REQ-032 RST asserted mid-GATE abandons the measurement; no Store is issued.
REQ-033 After RST falls, the first possible CLR is on the first clock edge with Run=1.

Configuration
REQ-034 Macro AUTORANGE_EN defined: autorange per REQ-022/023.
REQ-035 Macro AUTORANGE_EN undefined: Auto is ignored and treated as 0, F_sel always follows Man_sel at CLEAR, EVAL always -> STORE, and Ovr follows REQ-024 manual rule.

Verification (TICKS_1MS=10)
REQ-036 Auto=0, Man_sel=11, Run pulse 1 cycle: CLR 1 cycle, GATE high exactly 10 cycles, 2 idle cycles, EVAL, Store 1 cycle, then IDLE; Busy spans CLR to Store.
REQ-037 Auto=1 from reset (F_sel=00), CNT=12000 each EVAL: F_sel steps 00->01->10 with no Store; CNT=5000 at 10 -> Store with F_sel=10.
REQ-038 Auto=1 at F_sel=11, OVF=1: Store issued and Ovr=1; next cycle CNT=2000: Ovr=0 after Store.
REQ-039 Auto=1 at F_sel=10, CNT=500: F_sel=01 with no Store; CNT=999 at 00 -> Store with F_sel=00.
REQ-040 RST pulse at cycle 5 of GATE: all outputs 0 within the same cycle, and no Store follows.
REQ-041 Run=1 then dropped mid-GATE: exactly one Store, then IDLE with Busy=0.
